// File: rtl/axi_lite_pwm_pkg.sv
// Shared constants and types for the AXI-Lite PWM peripheral.
// Register offsets, write response codes and the write FSM state encoding.
package axi_lite_pwm_pkg;

    localparam logic [7:0] CTRL_OFS   = 8'h00;
    localparam logic [7:0] PRESC_OFS  = 8'h04;
    localparam logic [7:0] PERIOD_OFS = 8'h08;
    localparam logic [7:0] DUTY_OFS   = 8'h0C;
    localparam logic [7:0] POL_OFS    = 8'h10;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        RESP
    } state_t;

endpackage

// File: rtl/axi_lite_pwm_core.sv
// PWM engine: prescaler, period counter, shadow-register loading and comparator.
// The output is registered; pol selects the inactive level and inverts the waveform.
module pwm_core
    import axi_lite_pwm_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             pol,
    input  logic [CNT_W-1:0] presc,
    input  logic [CNT_W-1:0] period,
    input  logic [CNT_W-1:0] duty,
    output logic             pwm
);

    logic [CNT_W-1:0] pc;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period_a;
    logic [CNT_W-1:0] duty_a;
    logic [CNT_W-1:0] presc_m1;
    logic             tick;
    logic             wrap;
    logic             level;

    // >= rather than == so that lowering PRESC mid-count wraps at once
    always_comb begin
        presc_m1 = (presc == '0) ? '0 : presc - 1'b1;
        tick     = (pc >= presc_m1);
        wrap     = (period_a == '0) || (cnt >= period_a - 1'b1);
        level    = (period_a != '0) && (cnt < duty_a);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            cnt      <= '0;
            period_a <= '0;
            duty_a   <= '0;
            pwm      <= 1'b0;
        end else if (!enable) begin
            pc       <= '0;
            cnt      <= '0;
            period_a <= period;
            duty_a   <= duty;
            pwm      <= pol;
        end else begin
            pc  <= tick ? '0 : pc + 1'b1;
            pwm <= level ^ pol;
            if (tick) begin
                if (wrap) begin
                    cnt      <= '0;
                    period_a <= period;
                    duty_a   <= duty;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/axi_lite_pwm.sv
// Write-only AXI4-Lite PWM peripheral: CTRL/PRESC/PERIOD/DUTY registers feeding pwm_core.
// Define AXI_LITE_PWM_POLARITY_EN to add the POL register at 0x10.
module axi_lite_pwm
    import axi_lite_pwm_pkg::*;
#(
    parameter int CNT_W  = 32,
    parameter int ADDR_W = 32
) (
    input  logic              axi_lite_aclk,
    input  logic              axi_lite_areset,
    output logic              pwm,
    input  logic [ADDR_W-1:0] axi_lite_awaddr,
    input  logic              axi_lite_awvalid,
    output logic              axi_lite_awready,
    input  logic [31:0]       axi_lite_wdata,
    input  logic              axi_lite_wvalid,
    output logic              axi_lite_wready,
    output logic [1:0]        axi_lite_bresp,
    output logic              axi_lite_bvalid,
    input  logic              axi_lite_bready
);

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       ctrl;
    logic [CNT_W-1:0]  presc;
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  duty;
    logic              pol_bit;
    logic              addr_ok;
    logic              sel_ctrl;
    logic              sel_presc;
    logic              sel_period;
    logic              sel_duty;
    logic              unused_ctrl;

    assign unused_ctrl = ^ctrl[31:1];

`ifdef AXI_LITE_PWM_POLARITY_EN
    logic sel_pol;
    logic pol_q;
    assign pol_bit = pol_q;
`else
    assign pol_bit = 1'b0;
`endif

    always_comb begin
        addr_ok    = 1'b0;
        sel_ctrl   = 1'b0;
        sel_presc  = 1'b0;
        sel_period = 1'b0;
        sel_duty   = 1'b0;
`ifdef AXI_LITE_PWM_POLARITY_EN
        sel_pol    = 1'b0;
`endif
        if (addr_q[ADDR_W-1:8] == '0) begin
            case (addr_q[7:0])
                CTRL_OFS:   begin addr_ok = 1'b1; sel_ctrl   = 1'b1; end
                PRESC_OFS:  begin addr_ok = 1'b1; sel_presc  = 1'b1; end
                PERIOD_OFS: begin addr_ok = 1'b1; sel_period = 1'b1; end
                DUTY_OFS:   begin addr_ok = 1'b1; sel_duty   = 1'b1; end
                POL_OFS: begin
`ifdef AXI_LITE_PWM_POLARITY_EN
                    addr_ok = 1'b1;
                    sel_pol = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge axi_lite_aclk) begin
        if (axi_lite_areset) begin
            state            <= IDLE;
            addr_q           <= '0;
            axi_lite_awready <= 1'b1;
            axi_lite_wready  <= 1'b0;
            axi_lite_bvalid  <= 1'b0;
            axi_lite_bresp   <= BRESP_OKAY;
            ctrl             <= '0;
            presc            <= '0;
            period           <= '0;
            duty             <= '0;
`ifdef AXI_LITE_PWM_POLARITY_EN
            pol_q            <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (axi_lite_awvalid) begin
                        addr_q           <= axi_lite_awaddr;
                        axi_lite_awready <= 1'b0;
                        axi_lite_wready  <= 1'b1;
                        state            <= DATA;
                    end
                end
                DATA: begin
                    if (axi_lite_wvalid) begin
                        axi_lite_wready <= 1'b0;
                        axi_lite_bvalid <= 1'b1;
                        axi_lite_bresp  <= addr_ok ? BRESP_OKAY : BRESP_SLVERR;
                        if (sel_ctrl)   ctrl   <= axi_lite_wdata;
                        if (sel_presc)  presc  <= axi_lite_wdata[CNT_W-1:0];
                        if (sel_period) period <= axi_lite_wdata[CNT_W-1:0];
                        if (sel_duty)   duty   <= axi_lite_wdata[CNT_W-1:0];
`ifdef AXI_LITE_PWM_POLARITY_EN
                        if (sel_pol)    pol_q  <= axi_lite_wdata[0];
`endif
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (axi_lite_bready) begin
                        axi_lite_bvalid  <= 1'b0;
                        axi_lite_awready <= 1'b1;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    pwm_core #(
        .CNT_W(CNT_W)
    ) u_core (
        .clk    (axi_lite_aclk),
        .rst    (axi_lite_areset),
        .enable (ctrl[0]),
        .pol    (pol_bit),
        .presc  (presc),
        .period (period),
        .duty   (duty),
        .pwm    (pwm)
    );

endmodule

// File: tb/tb_axi_lite_pwm.sv
// Directed self-checking bench for axi_lite_pwm; PWM timing is scaled down
// (PRESC=4, PERIOD=10, DUTY=5 -> 20 high / 20 low) to keep the run short.
module tb_axi_lite_pwm;

    logic        clk;
    logic        rst;
    logic        pwm;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;
    int cyc     = 0;

    axi_lite_pwm #(
        .CNT_W (32),
        .ADDR_W(32)
    ) dut (
        .axi_lite_aclk   (clk),
        .axi_lite_areset (rst),
        .pwm             (pwm),
        .axi_lite_awaddr (awaddr),
        .axi_lite_awvalid(awvalid),
        .axi_lite_awready(awready),
        .axi_lite_wdata  (wdata),
        .axi_lite_wvalid (wvalid),
        .axi_lite_wready (wready),
        .axi_lite_bresp  (bresp),
        .axi_lite_bvalid (bvalid),
        .axi_lite_bready (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [1:0] exp_resp, input string tag);
        @(posedge clk); #1 awaddr = addr; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        @(posedge clk); #1 wdata = data; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        @(negedge clk);
        check({tag, "_bvalid"}, {31'd0, bvalid}, 32'd1);
        check({tag, "_bresp"}, {30'd0, bresp}, {30'd0, exp_resp});
        bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check({tag, "_bclr"}, {31'd0, bvalid}, 32'd0);
    endtask

    task automatic wait_level(input logic lvl, input string tag);
        int b = 0;
        while (pwm !== lvl && b < 400) begin
            @(negedge clk);
            b++;
        end
        if (pwm !== lvl) check({tag, "_timeout"}, {31'd0, pwm}, {31'd0, lvl});
    endtask

    // Waits for pwm==lvl, then returns the number of consecutive cycles at that level.
    task automatic next_run(input logic lvl, input string tag, output int n);
        wait_level(lvl, tag);
        n = 0;
        while (pwm === lvl && n < 400) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic count_high(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (pwm === 1'b1) n++;
        end
    endtask

    initial begin
        int n;
        int c0;
        rst = 1'b1; awaddr = '0; awvalid = 1'b0; wdata = '0; wvalid = 1'b0; bready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_pwm", {31'd0, pwm}, 32'd0);
        check("rst_awready", {31'd0, awready}, 32'd1);
        check("rst_wready", {31'd0, wready}, 32'd0);
        check("rst_bvalid", {31'd0, bvalid}, 32'd0);
        check("rst_bresp", {30'd0, bresp}, 32'd0);
        count_high(1000, n);
        check("idle_pwm_1000", n, 0);

        // single-cycle handshakes with wide gaps; PRESC=0, PERIOD=4, DUTY=2
        axi_write(32'h08, 32'd4, 2'b00, "period4");
        axi_write(32'h0C, 32'd2, 2'b00, "duty2");
        @(posedge clk); #1 awaddr = 32'h0; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        check("hs_awready_low", {31'd0, awready}, 32'd0);
        check("hs_wready_high", {31'd0, wready}, 32'd1);
        repeat (5) @(posedge clk);
        #1 wdata = 32'h02E9_0EDD; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        @(negedge clk);
        check("hs_wready_low", {31'd0, wready}, 32'd0);
        check("hs_bvalid", {31'd0, bvalid}, 32'd1);
        check("hs_bresp", {30'd0, bresp}, 32'd0);
        @(negedge clk);
        check("hs_enable_pwm", {31'd0, pwm}, 32'd1);
        repeat (4) @(posedge clk);
        check("hs_bvalid_hold", {31'd0, bvalid}, 32'd1);
        #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("hs_bvalid_clr", {31'd0, bvalid}, 32'd0);
        check("hs_awready_back", {31'd0, awready}, 32'd1);
        next_run(1'b0, "hs_sync", n);
        next_run(1'b1, "hs_high", n);
        check("hs_high_len", n, 2);
        next_run(1'b0, "hs_low", n);
        check("hs_low_len", n, 2);

        // full configuration
        axi_write(32'h00, 32'd0, 2'b00, "ctrl_off");
        axi_write(32'h04, 32'd4, 2'b00, "presc4");
        axi_write(32'h08, 32'd10, 2'b00, "period10");
        axi_write(32'h0C, 32'd5, 2'b00, "duty5");
        axi_write(32'h00, 32'd1, 2'b00, "ctrl_on");
        next_run(1'b0, "cfg_low1", n);
        check("cfg_low1_len", n, 20);
        next_run(1'b1, "cfg_high", n);
        check("cfg_high_len", n, 20);
        next_run(1'b0, "cfg_low2", n);
        check("cfg_low2_len", n, 20);

        // bad addresses
        axi_write(32'h14, 32'hFFFF_FFFF, 2'b10, "bad14");
        axi_write(32'h02, 32'hFFFF_FFFF, 2'b10, "bad02");
        axi_write(32'h100, 32'hFFFF_FFFF, 2'b10, "bad100");
`ifdef AXI_LITE_PWM_POLARITY_EN
        axi_write(32'h10, 32'd0, 2'b00, "pol10");
`else
        axi_write(32'h10, 32'hFFFF_FFFF, 2'b10, "pol10");
`endif
        next_run(1'b0, "bad_sync", n);
        next_run(1'b1, "bad_high", n);
        check("bad_high_len", n, 20);
        next_run(1'b0, "bad_low", n);
        check("bad_low_len", n, 20);

        // shadowing: DUTY written mid-period takes effect on the next period
        wait_level(1'b0, "sh_w0");
        wait_level(1'b1, "sh_w1");
        c0 = cyc;
        axi_write(32'h0C, 32'd2, 2'b00, "sh_duty2");
        wait_level(1'b0, "sh_fall");
        check("sh_cur_high_len", cyc - c0, 20);
        next_run(1'b0, "sh_cur_low", n);
        check("sh_cur_low_len", n, 20);
        next_run(1'b1, "sh_new_high", n);
        check("sh_new_high_len", n, 8);
        next_run(1'b0, "sh_new_low", n);
        check("sh_new_low_len", n, 32);

        axi_write(32'h0C, 32'd20, 2'b00, "duty20");
        repeat (90) @(negedge clk);
        count_high(80, n);
        check("duty_ge_period_high", n, 80);

        axi_write(32'h0C, 32'd0, 2'b00, "duty0");
        repeat (90) @(negedge clk);
        count_high(80, n);
        check("duty0_low", n, 0);

        axi_write(32'h0C, 32'd5, 2'b00, "duty5b");
        axi_write(32'h08, 32'd0, 2'b00, "period0");
        repeat (90) @(negedge clk);
        count_high(80, n);
        check("period0_low", n, 0);

        // disable drops pwm one cycle after the W handshake
        axi_write(32'h08, 32'd10, 2'b00, "period10b");
        axi_write(32'h0C, 32'd20, 2'b00, "duty20b");
        repeat (90) @(negedge clk);
        check("pre_disable_high", {31'd0, pwm}, 32'd1);
        @(posedge clk); #1 awaddr = 32'h0; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        @(posedge clk); #1 wdata = 32'd0; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("disable_pwm", {31'd0, pwm}, 32'd0);
        #1 bready = 1'b1;
        @(posedge clk); #1 bready = 1'b0;
        @(negedge clk);
        check("disable_bclr", {31'd0, bvalid}, 32'd0);

        // reset while in DATA discards the write
        @(posedge clk); #1 awaddr = 32'h0; awvalid = 1'b1;
        @(posedge clk); #1 awvalid = 1'b0;
        @(negedge clk);
        check("mid_in_data", {31'd0, wready}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("mid_awready", {31'd0, awready}, 32'd1);
        check("mid_wready", {31'd0, wready}, 32'd0);
        check("mid_bvalid", {31'd0, bvalid}, 32'd0);
        #1 wdata = 32'd1; wvalid = 1'b1;
        @(posedge clk); #1 wvalid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_no_resp", {31'd0, bvalid}, 32'd0);
        check("mid_still_idle", {31'd0, awready}, 32'd1);
        count_high(40, n);
        check("mid_pwm_low", n, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
